bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader_pkg.sv | 16 +
 rtl/skid_fifo2.sv | 50 +++++
 rtl/bram_stream_reader.sv | 115 +++++++++++
 tb/tb_bram_stream_reader.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_reader_pkg.sv
// Purpose : shared memory-controller definitions (FSM encodings, default geometry).
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package bram_stream_reader_pkg;

   localparam int DEF_DWIDTH   = 16;
   localparam int DEF_AWIDTH   = 7;
   localparam int DEF_MEM_SIZE = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Purpose : two-entry FIFO buffering BRAM read data ahead of the stream port.
// Latency : a push is visible at the head on the cycle after the push edge.
// Backpr. : the head holds while i_pop is low; the writer must not push when full.
// Ports   : i_push/i_data write side, i_pop read strobe, o_valid = not empty,
//           o_data = head word, o_count = occupancy (0..2).
module skid_fifo2 #(
   parameter int DWIDTH = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_push,
   input  logic [DWIDTH-1:0] i_data,
   input  logic              i_pop,
   output logic              o_valid,
   output logic [DWIDTH-1:0] o_data,
   output logic [1:0]        o_count
);

   logic [DWIDTH-1:0] r_mem [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;
   logic              w_pop;

   // Popping an empty FIFO is treated as a no-op.
   assign w_pop   = i_pop & (r_count != 2'd0);
   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Purpose : streams num_cnt words from a BRAM read port, starting at base, as valid/ready.
// Latency : first o_valid in the third cycle after the edge sampling i_run, then 1 word/cycle.
// Backpr. : reads are throttled so FIFO + in-flight words never exceed two; i_ready low stalls.
// Ports   : i_run/i_base_addr/i_num_cnt start a job; o_idle/o_read/o_done one-hot state;
//           addr1/ce1/we1/d1/q1 BRAM port B (read-only use); o_valid/o_data/i_ready stream.
module bram_stream_reader
   import bram_stream_reader_pkg::*;
#(
   parameter int DWIDTH   = DEF_DWIDTH,
   parameter int AWIDTH   = DEF_AWIDTH,
   parameter int MEM_SIZE = DEF_MEM_SIZE
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_run,
   input  logic [AWIDTH-1:0] i_base_addr,
   input  logic [AWIDTH-1:0] i_num_cnt,
   output logic              o_idle,
   output logic              o_read,
   output logic              o_done,
   output logic [AWIDTH-1:0] addr1,
   output logic              ce1,
   output logic              we1,
   output logic [DWIDTH-1:0] d1,
   input  logic [DWIDTH-1:0] q1,
   output logic              o_valid,
   output logic [DWIDTH-1:0] o_data,
   input  logic              i_ready
);

   localparam logic [AWIDTH-1:0] ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

   // The address counter wraps at 2^AWIDTH, so a deeper memory could not be covered.
   if (MEM_SIZE > (1 << AWIDTH)) begin : g_size_chk
      $error("MEM_SIZE exceeds the AWIDTH address space");
   end

   state_t            r_state;
   state_t            w_next;
   logic [AWIDTH-1:0] r_base;
   logic [AWIDTH-1:0] r_num;
   logic [AWIDTH-1:0] r_issue_cnt;
   logic [AWIDTH-1:0] r_xfer_cnt;
   logic              r_inflight;   // a read issued last cycle: q1 is valid this cycle
   logic              w_start;
   logic              w_pop;
   logic              w_room;
   logic              w_issue;
   logic              w_last_xfer;
   logic [1:0]        w_fifo_cnt;

   assign w_start = (r_state == ST_IDLE) && i_run;
   assign w_pop   = o_valid & i_ready;

   // Count a same-cycle pop as freed space so a full pipeline keeps one word per cycle.
   assign w_room  = ({1'b0, w_fifo_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
   assign w_issue = (r_state == ST_READ) && (r_issue_cnt < r_num) && w_room;
   assign w_last_xfer = w_pop && (r_xfer_cnt == (r_num - ONE));

   assign ce1   = w_issue;
   assign addr1 = w_issue ? (r_base + r_issue_cnt) : '0;
   assign we1   = 1'b0;
   assign d1    = '0;

   assign o_idle = (r_state == ST_IDLE);
   assign o_read = (r_state == ST_READ);
   assign o_done = (r_state == ST_DONE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (i_run) w_next = (i_num_cnt == '0) ? ST_DONE : ST_READ;
         ST_READ: if (w_last_xfer) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_base      <= '0;
         r_num       <= '0;
         r_issue_cnt <= '0;
         r_xfer_cnt  <= '0;
         r_inflight  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_inflight <= w_issue;
         if (w_start) begin
            r_base      <= i_base_addr;
            r_num       <= i_num_cnt;
            r_issue_cnt <= '0;
            r_xfer_cnt  <= '0;
         end else begin
            if (w_issue) r_issue_cnt <= r_issue_cnt + ONE;
            if (w_pop)   r_xfer_cnt  <= r_xfer_cnt + ONE;
         end
      end
   end

   skid_fifo2 #(
      .DWIDTH (DWIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (r_inflight),
      .i_data  (q1),
      .i_pop   (w_pop),
      .o_valid (o_valid),
      .o_data  (o_data),
      .o_count (w_fifo_cnt)
   );

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

   localparam int DW = 16;
   localparam int AW = 7;
   localparam int MS = 128;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_run = 1'b0;
   logic [AW-1:0] i_base_addr = '0;
   logic [AW-1:0] i_num_cnt = '0;
   logic          o_idle, o_read, o_done;
   logic [AW-1:0] addr1;
   logic          ce1, we1;
   logic [DW-1:0] d1;
   logic [DW-1:0] q1;
   logic          o_valid;
   logic [DW-1:0] o_data;
   logic          i_ready = 1'b0;

   always #5 clk = ~clk;

   bram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
      .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_base_addr(i_base_addr),
      .i_num_cnt(i_num_cnt), .o_idle(o_idle), .o_read(o_read), .o_done(o_done),
      .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1),
      .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready)
   );

   // BRAM port B model (1-cycle registered read); port A writes go straight into mem.
   logic [DW-1:0] mem [MS];
   always @(posedge clk) if (ce1) q1 <= mem[addr1];

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observation state for one job.
   logic [DW-1:0] got_q [$];
   int   cyc, n_iss, n_xfr, max_occ, done_cnt, done_cyc, first_vld;
   int   stall_err, side_err, hot_err, idle_after;
   logic prev_stall;
   logic [DW-1:0] prev_data;

   task automatic clear_obs();
      got_q.delete();
      cyc = 0; n_iss = 0; n_xfr = 0; max_occ = 0; done_cnt = 0; done_cyc = -1;
      first_vld = -1; stall_err = 0; side_err = 0; hot_err = 0; idle_after = 0;
      prev_stall = 1'b0; prev_data = '0;
   endtask

   task automatic tick(input logic run, input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                       input logic rdy);
      @(negedge clk);
      i_run = run; i_base_addr = base; i_num_cnt = cnt; i_ready = rdy;
      #1;
      // words issued but not yet handed out = FIFO + in-flight occupancy
      if (n_iss - n_xfr > max_occ) max_occ = n_iss - n_xfr;
      if (int'(o_idle) + int'(o_read) + int'(o_done) != 1) hot_err++;
      if (we1 !== 1'b0 || d1 !== '0) side_err++;
      if (prev_stall && (!o_valid || o_data !== prev_data)) stall_err++;
      if (o_valid && first_vld < 0) first_vld = cyc;
      if (done_cnt > 0 && cyc == done_cyc + 1) idle_after = (o_idle && !o_done) ? 1 : 0;
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (ce1) n_iss++;
      if (o_valid && i_ready) begin got_q.push_back(o_data); n_xfr++; end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      cyc++;
   endtask

   task automatic run_stream(input string tag, input logic [AW-1:0] base,
                             input logic [AW-1:0] cnt, input int rnd_ready, input int inject);
      int n;
      int a;
      clear_obs();
      tick(1'b1, base, cnt, rnd_ready != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
      while (!(done_cnt > 0 && cyc > done_cyc + 1) && cyc < 600) begin
         logic r;
         r = (rnd_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (inject != 0 && cyc == 4) tick(1'b1, base + 7'd50, cnt + 7'd3, r);
         else                         tick(1'b0, base, cnt, r);
      end
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_idle_after_done"}, idle_after, 1);
      chk({tag, "_word_count"}, got_q.size(), int'(cnt));
      n = (got_q.size() < int'(cnt)) ? got_q.size() : int'(cnt);
      for (int k = 0; k < n; k++) begin
         a = (int'(base) + k) % MS;
         chk($sformatf("%s_word%0d", tag, k), got_q[k], mem[a]);
      end
      chk({tag, "_occ_over_2"}, (max_occ > 2) ? 1 : 0, 0);
      chk({tag, "_stall_unstable"}, stall_err, 0);
      chk({tag, "_write_side"}, side_err, 0);
      chk({tag, "_state_onehot"}, hot_err, 0);
      if (rnd_ready == 0 && cnt != '0) begin
         chk({tag, "_first_valid_cyc"}, first_vld, 3);
         chk({tag, "_done_cyc"}, done_cyc, 3 + int'(cnt));
      end
      if (cnt == '0) begin
         chk({tag, "_ce1_issues"}, n_iss, 0);
         chk({tag, "_valid_seen"}, first_vld, -1);
         chk({tag, "_done_cyc"}, done_cyc, 1);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_o_idle"}, o_idle, 1);
      chk({tag, "_o_read"}, o_read, 0);
      chk({tag, "_o_done"}, o_done, 0);
      chk({tag, "_ce1"}, ce1, 0);
      chk({tag, "_we1"}, we1, 0);
      chk({tag, "_addr1"}, addr1, 0);
      chk({tag, "_d1"}, d1, 0);
      chk({tag, "_o_valid"}, o_valid, 0);
      chk({tag, "_o_data"}, o_data, 0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < MS; i++) mem[i] = (16'($urandom) & 16'hFF80) | 16'(i);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      fill_random();
      #3;
      chk_reset_outputs("por");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // port A preload 0..99
      for (int i = 0; i < 100; i++) mem[i] = 16'(i);
      run_stream("seq100", 7'd0, 7'd100, 0, 0);

      fill_random();
      run_stream("wrap", 7'd120, 7'd16, 0, 0);
      run_stream("zero", 7'd0, 7'd0, 0, 0);
      run_stream("stall", 7'($urandom_range(0, MS - 1)), 7'd10, 1, 0);
      run_stream("stall2", 7'd125, 7'd9, 1, 0);
      run_stream("ignore_run", 7'd30, 7'd12, 0, 1);

      // reset in the middle of a cnt=20 run
      clear_obs();
      tick(1'b1, 7'd60, 7'd20, 1'b1);
      while (n_xfr < 5 && cyc < 100) tick(1'b0, 7'd60, 7'd20, 1'b1);
      chk("midrst_reached_5", n_xfr, 5);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("midrst_hold%0d_o_done", i), o_done, 0);
         chk($sformatf("midrst_hold%0d_o_valid", i), o_valid, 0);
      end
      reset_n = 1'b1;
      clear_obs();
      repeat (8) tick(1'b0, 7'd60, 7'd20, 1'b1);
      chk("postrst_done_pulses", done_cnt, 0);
      chk("postrst_words", n_xfr, 0);
      chk("postrst_ce1", n_iss, 0);
      run_stream("fresh", 7'd60, 7'd20, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
